// File: rtl/fir_sum_pkg.sv
// Shared constants and helpers for the FIR final-sum stage.
// Optional build macro FIR_SUM_ROUND_EN (used by fir_sum_sat_stage) selects
// round-half-up instead of floor truncation ahead of the right shift.
package fir_sum_pkg;

  // Ceiling log2; returns 0 for n <= 1
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Width of the tree sum: input width plus one growth bit per level
  function automatic int sum_width(input int in_w, input int num_mac);
    return in_w + clog2(num_mac);
  endfunction

  // Valid pipeline depth: one bit per tree level plus the output register
  function automatic int vld_depth(input int num_mac);
    return clog2(num_mac) + 1;
  endfunction

  // Valid pipeline depth for the default 4-lane configuration
  localparam int DEF_VLD_DEPTH = vld_depth(4);

  // Largest signed value representable in out_w bits
  function automatic logic signed [63:0] sat_max(input int out_w);
    logic signed [63:0] one;
    one = 64'sd1;
    return (one <<< (out_w - 1)) - one;
  endfunction

  // Smallest signed value representable in out_w bits
  function automatic logic signed [63:0] sat_min(input int out_w);
    logic signed [63:0] one;
    one = 64'sd1;
    return -(one <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/fir_sum_sat_stage.sv
// Round/shift, saturation and output/statistics registers of the FIR final sum.
// FIR_SUM_ROUND_EN defined: round half up before the shift; undefined: floor.
module fir_sum_sat_stage
  import fir_sum_pkg::*;
#(
  parameter int SUM_W     = 18,
  parameter int OUT_W     = 16,
  parameter int SHIFT     = 0,
  parameter int SAT_CNT_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    vld_i,
  input  logic signed [SUM_W-1:0] sum_i,
  input  logic                    sat_clr_i,
  output logic [OUT_W-1:0]        out_o,
  output logic                    vld_o,
  output logic                    sat_flag_o,
  output logic [SAT_CNT_W-1:0]    sat_cnt_o
);

  localparam logic signed [63:0]     SMAX    = sat_max(OUT_W);
  localparam logic signed [63:0]     SMIN    = sat_min(OUT_W);
  localparam logic [SAT_CNT_W-1:0]   CNT_TOP = {SAT_CNT_W{1'b1}};

  logic signed [SUM_W:0]   ext_s;
  logic signed [SUM_W:0]   r_s;
  logic signed [63:0]      r64_s;
  logic                    hi_s;
  logic                    lo_s;
  logic [OUT_W-1:0]        sat_val_s;

  logic [OUT_W-1:0]        out_d, out_q;
  logic                    vld_q;
  logic                    flag_d, flag_q;
  logic [SAT_CNT_W-1:0]    cnt_d, cnt_q;

  // One extra bit of headroom so the rounding addend cannot overflow
  assign ext_s = (SUM_W+1)'(sum_i);

  if (SHIFT > 0) begin : g_shift
`ifdef FIR_SUM_ROUND_EN
    localparam logic [SUM_W:0] RND = {{SUM_W{1'b0}}, 1'b1} << (SHIFT - 1);
    assign r_s = (ext_s + $signed(RND)) >>> SHIFT;
`else
    assign r_s = ext_s >>> SHIFT;
`endif
  end else begin : g_noshift
    assign r_s = ext_s;
  end

  assign r64_s = 64'(r_s);
  assign hi_s  = (r64_s > SMAX);
  assign lo_s  = (r64_s < SMIN);

  // Clamp the shifted sum to the signed output range
  always_comb begin
    sat_val_s = r_s[OUT_W-1:0];
    if (hi_s) begin
      sat_val_s = SMAX[OUT_W-1:0];
    end else if (lo_s) begin
      sat_val_s = SMIN[OUT_W-1:0];
    end else begin
      sat_val_s = r_s[OUT_W-1:0];
    end
  end

  // Next output and statistics; a clear overrides any saturation event
  always_comb begin
    out_d  = out_q;
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (vld_i) begin
      out_d = sat_val_s;
      if (hi_s || lo_s) begin
        flag_d = 1'b1;
        cnt_d  = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + SAT_CNT_W'(1);
      end else begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
      end
    end else begin
      out_d = out_q;
    end
    if (sat_clr_i) begin
      flag_d = 1'b0;
      cnt_d  = '0;
    end else begin
      flag_d = flag_d;
    end
  end

  // Output and statistics registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_q  <= '0;
      vld_q  <= 1'b0;
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      out_q  <= out_d;
      vld_q  <= vld_i;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_o      = out_q;
  assign vld_o      = vld_q;
  assign sat_flag_o = flag_q;
  assign sat_cnt_o  = cnt_q;

endmodule

// File: rtl/fir_final_sum_sat.sv
// FIR final-sum stage: pipelined signed adder tree over NUM_MAC partials,
// followed by round/shift/saturate (fir_sum_sat_stage).
// Build macro FIR_SUM_ROUND_EN enables round-half-up before the shift.
module fir_final_sum_sat
  import fir_sum_pkg::*;
#(
  parameter int NUM_MAC   = 4,
  parameter int IN_W      = 16,
  parameter int OUT_W     = 16,
  parameter int SHIFT     = 0,
  parameter int SAT_CNT_W = 8
) (
  input  logic                    iClk_12M,
  input  logic                    iRsn,
  input  logic                    iEnDelay,
  input  logic [NUM_MAC*IN_W-1:0] iMac,
  input  logic                    iSatClr,
  output logic [OUT_W-1:0]        oFirOut,
  output logic                    oFirValid,
  output logic                    oSatFlag,
  output logic [SAT_CNT_W-1:0]    oSatCnt
);

  localparam int LEV       = clog2(NUM_MAC);
  localparam int SUM_W     = sum_width(IN_W, NUM_MAC);
  localparam int NODES     = 1 << LEV;
  localparam int TREE_VLDS = vld_depth(NUM_MAC) - 1;

  // tree_s[l][k] is node k of level l; unused slots are tied to zero, which
  // also provides the zero operand at odd-count levels
  logic signed [SUM_W-1:0] tree_s [LEV+1][NODES];
  logic                    stage_vld_s;

  genvar gl, gk;

  for (gk = 0; gk < NODES; gk++) begin : g_in
    if (gk < NUM_MAC) begin : g_lane
      logic signed [IN_W-1:0] lane_s;
      assign lane_s       = iMac[gk*IN_W +: IN_W];
      assign tree_s[0][gk] = SUM_W'(lane_s);
    end else begin : g_pad
      assign tree_s[0][gk] = '0;
    end
  end

  for (gl = 1; gl <= LEV; gl++) begin : g_lvl
    localparam int W = NODES >> gl;
    logic signed [SUM_W-1:0] node_d [W];
    logic signed [SUM_W-1:0] node_q [W];

    // Pairwise sums of the level below
    always_comb begin
      for (int k = 0; k < W; k++) begin
        node_d[k] = tree_s[gl-1][2*k] + tree_s[gl-1][2*k+1];
      end
    end

    // One pipeline register per tree level
    always_ff @(posedge iClk_12M) begin
      if (!iRsn) begin
        for (int k = 0; k < W; k++) node_q[k] <= '0;
      end else begin
        for (int k = 0; k < W; k++) node_q[k] <= node_d[k];
      end
    end

    for (gk = 0; gk < NODES; gk++) begin : g_out
      if (gk < W) begin : g_used
        assign tree_s[gl][gk] = node_q[gk];
      end else begin : g_zero
        assign tree_s[gl][gk] = '0;
      end
    end
  end

  if (TREE_VLDS == 0) begin : g_vld_none
    assign stage_vld_s = iEnDelay;
  end else begin : g_vld_pipe
    logic [TREE_VLDS-1:0] vld_d, vld_q;

    // Shift the input strobe alongside the tree data
    always_comb begin
      vld_d    = vld_q << 1;
      vld_d[0] = iEnDelay;
    end

    // Valid shift register; reset drops in-flight samples
    always_ff @(posedge iClk_12M) begin
      if (!iRsn) begin
        vld_q <= '0;
      end else begin
        vld_q <= vld_d;
      end
    end

    assign stage_vld_s = vld_q[TREE_VLDS-1];
  end

  fir_sum_sat_stage #(
    .SUM_W     (SUM_W),
    .OUT_W     (OUT_W),
    .SHIFT     (SHIFT),
    .SAT_CNT_W (SAT_CNT_W)
  ) u_sat (
    .clk_i      (iClk_12M),
    .rst_n_i    (iRsn),
    .vld_i      (stage_vld_s),
    .sum_i      (tree_s[LEV][0]),
    .sat_clr_i  (iSatClr),
    .out_o      (oFirOut),
    .vld_o      (oFirValid),
    .sat_flag_o (oSatFlag),
    .sat_cnt_o  (oSatCnt)
  );

endmodule

// File: tb/tb_fir_final_sum_sat.sv
// Self-checking bench for fir_final_sum_sat: default 4-lane build plus
// NUM_MAC=3, NUM_MAC=1 and SHIFT=2 instances.
module tb_fir_final_sum_sat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rsn, clr;
  logic        en, en3, en1, ens;
  logic [63:0] mac, macs;
  logic [47:0] mac3;
  logic [15:0] mac1;
  logic [15:0] out, out3, out1, outs;
  logic        vld, vld3, vld1, vlds;
  logic        flag, flag3, flag1, flags;
  logic [7:0]  cnt, cnt3, cnt1, cnts;

  int n_chk = 0;
  int n_fail = 0;

  fir_final_sum_sat dut (
    .iClk_12M(clk), .iRsn(rsn), .iEnDelay(en), .iMac(mac), .iSatClr(clr),
    .oFirOut(out), .oFirValid(vld), .oSatFlag(flag), .oSatCnt(cnt));

  fir_final_sum_sat #(.NUM_MAC(3)) dut3 (
    .iClk_12M(clk), .iRsn(rsn), .iEnDelay(en3), .iMac(mac3), .iSatClr(1'b0),
    .oFirOut(out3), .oFirValid(vld3), .oSatFlag(flag3), .oSatCnt(cnt3));

  fir_final_sum_sat #(.NUM_MAC(1)) dut1 (
    .iClk_12M(clk), .iRsn(rsn), .iEnDelay(en1), .iMac(mac1), .iSatClr(1'b0),
    .oFirOut(out1), .oFirValid(vld1), .oSatFlag(flag1), .oSatCnt(cnt1));

  fir_final_sum_sat #(.SHIFT(2)) duts (
    .iClk_12M(clk), .iRsn(rsn), .iEnDelay(ens), .iMac(macs), .iSatClr(1'b0),
    .oFirOut(outs), .oFirValid(vlds), .oSatFlag(flags), .oSatCnt(cnts));

  typedef struct {
    logic [63:0] mac;
    logic [15:0] out;
    logic        flag;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] lane;
    logic [15:0] exp_p, exp_n;

    vt[0] = '{{16'h1000, 16'h1000, 16'h1000, 16'h1000}, 16'h4000, 1'b0, 8'd0};
    vt[1] = '{{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 16'h7FFF, 1'b1, 8'd1};
    vt[2] = '{{16'h8000, 16'h8000, 16'h8000, 16'h8000}, 16'h8000, 1'b1, 8'd2};
    vt[3] = '{{16'h0000, 16'h0000, 16'h0000, 16'h7FFF}, 16'h7FFF, 1'b1, 8'd2};
    vt[4] = '{{16'h0000, 16'h0000, 16'h0000, 16'h8000}, 16'h8000, 1'b1, 8'd2};
    vt[5] = '{{16'h0003, 16'hFFFF, 16'h0002, 16'h0001}, 16'h0005, 1'b1, 8'd2};
    vt[6] = '{{16'h0000, 16'h0000, 16'h4000, 16'h4000}, 16'h7FFF, 1'b1, 8'd3};
    vt[7] = '{{16'h0000, 16'h0000, 16'hBFFF, 16'hC000}, 16'h8000, 1'b1, 8'd4};

    rsn = 1'b0; clr = 1'b0;
    en = 1'b0; en3 = 1'b0; en1 = 1'b0; ens = 1'b0;
    mac = '0; mac3 = '0; mac1 = '0; macs = '0;
    tick; tick;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_flag", 32'(flag), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    rsn = 1'b1;
    tick;

    // Table: one strobe each, latency 3, output holds afterwards
    for (int i = 0; i < 8; i++) begin
      mac = vt[i].mac; en = 1'b1;
      tick;
      en = 1'b0;
      chk("vec_lat1", 32'(vld), 32'h0);
      tick;
      chk("vec_lat2", 32'(vld), 32'h0);
      tick;
      chk("vec_vld", 32'(vld), 32'h1);
      chk("vec_out", 32'(out), 32'(vt[i].out));
      chk("vec_flag", 32'(flag), 32'(vt[i].flag));
      chk("vec_cnt", 32'(cnt), 32'(vt[i].cnt));
      tick;
      chk("vec_pulse", 32'(vld), 32'h0);
      chk("vec_hold", 32'(out), 32'(vt[i].out));
    end

    // Back-to-back strobes on 5 cycles
    for (int t = 0; t < 9; t++) begin
      if (t < 5) begin
        lane = 16'((t + 1) * 256);
        mac = {lane, lane, lane, lane};
        en = 1'b1;
      end else begin
        en = 1'b0;
      end
      tick;
      if (t >= 2 && t <= 6) begin
        chk("b2b_vld", 32'(vld), 32'h1);
        chk("b2b_out", 32'(out), 32'((t - 1) * 1024));
      end else begin
        chk("b2b_idle", 32'(vld), 32'h0);
      end
    end

    // NUM_MAC=3: latency 3
    mac3 = {16'h0300, 16'h0200, 16'h0100}; en3 = 1'b1;
    tick;
    en3 = 1'b0;
    chk("m3_lat1", 32'(vld3), 32'h0);
    tick;
    chk("m3_lat2", 32'(vld3), 32'h0);
    tick;
    chk("m3_vld", 32'(vld3), 32'h1);
    chk("m3_out", 32'(out3), 32'h0600);

    // NUM_MAC=1: latency 1
    mac1 = 16'h1234; en1 = 1'b1;
    tick;
    en1 = 1'b0;
    chk("m1_vld", 32'(vld1), 32'h1);
    chk("m1_out", 32'(out1), 32'h1234);
    tick;
    chk("m1_pulse", 32'(vld1), 32'h0);

    // SHIFT=2 with sums +6 and -6
`ifdef FIR_SUM_ROUND_EN
    exp_p = 16'h0002; exp_n = 16'hFFFF;
`else
    exp_p = 16'h0001; exp_n = 16'hFFFE;
`endif
    macs = {48'h0, 16'h0006}; ens = 1'b1;
    tick;
    macs = {48'h0, 16'hFFFA};
    tick;
    ens = 1'b0;
    tick;
    chk("sh_vld_p", 32'(vlds), 32'h1);
    chk("sh_out_p", 32'(outs), 32'(exp_p));
    tick;
    chk("sh_vld_n", 32'(vlds), 32'h1);
    chk("sh_out_n", 32'(outs), 32'(exp_n));

    // 260 saturating samples: counter holds at 255
    mac = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    en = 1'b1;
    for (int i = 0; i < 260; i++) tick;
    en = 1'b0;
    tick; tick; tick;
    chk("cnt_hold", 32'(cnt), 32'd255);
    chk("cnt_flag", 32'(flag), 32'h1);

    // Clear in the same cycle as a saturating output
    en = 1'b1;
    tick;
    en = 1'b0;
    tick;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("clr_vld", 32'(vld), 32'h1);
    chk("clr_out", 32'(out), 32'h7FFF);
    chk("clr_flag", 32'(flag), 32'h0);
    chk("clr_cnt", 32'(cnt), 32'h0);

    // Counting resumes after the clear
    en = 1'b1;
    tick;
    en = 1'b0;
    tick; tick;
    chk("post_clr_cnt", 32'(cnt), 32'h1);
    chk("post_clr_flag", 32'(flag), 32'h1);

    // Reset one cycle after a strobe drops the in-flight sample
    mac = {16'h1000, 16'h1000, 16'h1000, 16'h1000}; en = 1'b1;
    tick;
    en = 1'b0; rsn = 1'b0;
    tick;
    rsn = 1'b1;
    chk("mid_rst_out", 32'(out), 32'h0);
    chk("mid_rst_vld", 32'(vld), 32'h0);
    chk("mid_rst_flag", 32'(flag), 32'h0);
    chk("mid_rst_cnt", 32'(cnt), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("mid_rst_novld", 32'(vld), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
